// File: rtl/dlx_ctrl_pipe.sv
// dlx_ctrl_pipe: DLX control decode plus ID/EX, EX/MEM, MEM/WB control registers and RAW stall.
// Optional DLX_CTRL_FORWARD_EN adds fwd_a_o/fwd_b_o and limits stalls to load-use.
module dlx_ctrl_pipe #(
  parameter int                FUNC_W       = 6,
  parameter int                REG_AW       = 5,
  parameter int                LINK_REG     = 31,
  parameter logic [FUNC_W-1:0] DEFAULT_FUNC = 6'h22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [FUNC_W-1:0] ex_func_o,
  output logic              ex_imm_sel_o,
  output logic              ex_zero_ext_o,
  output logic [1:0]        ex_branch_o,
  output logic [1:0]        ex_jmp_o,
  output logic              ex_link_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  output logic [1:0]        mem_size_o,
  output logic              mem_signed_o,
  output logic              wb_reg_wr_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              wb_mem_to_reg_o,
  output logic              illegal_op_o
`ifdef DLX_CTRL_FORWARD_EN
  ,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
`endif
);

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic              imm_sel;
    logic              zero_ext;
    logic [1:0]        branch;
    logic [1:0]        jmp;
    logic              link;
    logic              mem_wr;
    logic              mem_rd;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic              reg_wr;
    logic [REG_AW-1:0] rd;
    logic              mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic              mem_wr;
    logic              mem_rd;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic              reg_wr;
    logic [REG_AW-1:0] rd;
    logic              mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic              reg_wr;
    logic [REG_AW-1:0] rd;
    logic              mem_to_reg;
  } wb_ctrl_t;

  ex_ctrl_t  idex_q, idex_d;
  mem_ctrl_t exmem_q, exmem_d;
  wb_ctrl_t  memwb_q, memwb_d;
  logic      illegal_q, illegal_d;

  ex_ctrl_t          ctrl_bubble;
  ex_ctrl_t          dec;
  logic              dec_illegal;
  logic              reads_rs1;
  logic              reads_rs2;
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic              hazard;
  logic              raw_stall;
  logic              unused_inst;

  assign opcode      = inst_i[31:26];
  assign rs1         = REG_AW'(inst_i[25:21]);
  assign rs2         = REG_AW'(inst_i[20:16]);
  assign unused_inst = ^inst_i[10:6];

  always_comb begin
    ctrl_bubble      = '0;
    ctrl_bubble.func = DEFAULT_FUNC;
  end

  // Instruction decode; unknown opcodes fall through to a bubble.
  always_comb begin
    dec         = ctrl_bubble;
    dec_illegal = 1'b0;
    reads_rs1   = 1'b0;
    reads_rs2   = 1'b0;
    case (opcode)
      6'h00, 6'h01: begin
        dec.func   = FUNC_W'(inst_i[5:0]);
        dec.reg_wr = 1'b1;
        dec.rd     = REG_AW'(inst_i[15:11]);
        reads_rs1  = 1'b1;
        reads_rs2  = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
        dec.func     = FUNC_W'(opcode + 6'h18);
        dec.imm_sel  = 1'b1;
        dec.zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
        dec.reg_wr   = 1'b1;
        dec.rd       = rs2;
        reads_rs1    = 1'b1;
      end
      6'h14, 6'h16, 6'h17: begin
        dec.func    = FUNC_W'(opcode - 6'h10);
        dec.imm_sel = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.rd      = rs2;
        reads_rs1   = 1'b1;
      end
      6'h0F: begin
        dec.imm_sel = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.rd      = rs2;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.func       = FUNC_W'(6'h20);
        dec.imm_sel    = 1'b1;
        dec.mem_rd     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_size   = (opcode[1:0] == 2'b11) ? 2'b10 : {1'b0, opcode[0]};
        dec.mem_signed = ~opcode[2];
        dec.reg_wr     = 1'b1;
        dec.rd         = rs2;
        reads_rs1      = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.func     = FUNC_W'(6'h20);
        dec.imm_sel  = 1'b1;
        dec.mem_wr   = 1'b1;
        dec.mem_size = (opcode[1:0] == 2'b11) ? 2'b10 : {1'b0, opcode[0]};
        reads_rs1    = 1'b1;
        reads_rs2    = 1'b1;
      end
      6'h04, 6'h05: begin
        dec.branch = {opcode[0], 1'b1};
        reads_rs1  = 1'b1;
      end
      6'h02, 6'h03: begin
        dec.jmp    = 2'b01;
        dec.link   = opcode[0];
        dec.reg_wr = opcode[0];
        dec.rd     = opcode[0] ? REG_AW'(LINK_REG) : '0;
      end
      6'h12, 6'h13: begin
        dec.jmp    = 2'b11;
        dec.link   = opcode[0];
        dec.reg_wr = opcode[0];
        dec.rd     = opcode[0] ? REG_AW'(LINK_REG) : '0;
        reads_rs1  = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec.rd == '0) dec.reg_wr = 1'b0;
  end

  assign ex_hit_a  = reads_rs1 && idex_q.reg_wr && (idex_q.rd != '0) && (idex_q.rd == rs1);
  assign ex_hit_b  = reads_rs2 && idex_q.reg_wr && (idex_q.rd != '0) && (idex_q.rd == rs2);
  assign mem_hit_a = reads_rs1 && exmem_q.reg_wr && (exmem_q.rd != '0) && (exmem_q.rd == rs1);
  assign mem_hit_b = reads_rs2 && exmem_q.reg_wr && (exmem_q.rd != '0) && (exmem_q.rd == rs2);

`ifdef DLX_CTRL_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  assign hazard = idex_q.mem_rd && (ex_hit_a || ex_hit_b);

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (inst_valid_i && !flush_i && !raw_stall) begin
      fwd_a_d = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
      fwd_b_d = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;
`else
  assign hazard = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
`endif

  assign raw_stall = inst_valid_i && hazard;
  // A flushed ID instruction is dead, so fetch must not hold it in IR.
  assign stall_o   = !rst_i && !flush_i && raw_stall;

  always_comb begin
    if (flush_i || raw_stall || !inst_valid_i) idex_d = ctrl_bubble;
    else                                       idex_d = dec;

    exmem_d.mem_wr     = idex_q.mem_wr;
    exmem_d.mem_rd     = idex_q.mem_rd;
    exmem_d.mem_size   = idex_q.mem_size;
    exmem_d.mem_signed = idex_q.mem_signed;
    exmem_d.reg_wr     = idex_q.reg_wr;
    exmem_d.rd         = idex_q.rd;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;

    memwb_d.reg_wr     = exmem_q.reg_wr;
    memwb_d.rd         = exmem_q.rd;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;

    illegal_d = illegal_q || (inst_valid_i && !flush_i && dec_illegal);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q    <= ctrl_bubble;
      exmem_q   <= '0;
      memwb_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_func_o       = idex_q.func;
  assign ex_imm_sel_o    = idex_q.imm_sel;
  assign ex_zero_ext_o   = idex_q.zero_ext;
  assign ex_branch_o     = idex_q.branch;
  assign ex_jmp_o        = idex_q.jmp;
  assign ex_link_o       = idex_q.link;
  assign mem_wr_o        = exmem_q.mem_wr;
  assign mem_rd_o        = exmem_q.mem_rd;
  assign mem_size_o      = exmem_q.mem_size;
  assign mem_signed_o    = exmem_q.mem_signed;
  assign wb_reg_wr_o     = memwb_q.reg_wr;
  assign wb_rd_o         = memwb_q.rd;
  assign wb_mem_to_reg_o = memwb_q.mem_to_reg;
  assign illegal_op_o    = illegal_q;

endmodule

// File: tb/tb_dlx_ctrl_pipe.sv
// Scoreboard bench for dlx_ctrl_pipe: directed program plus random instruction stream,
// checked against an instruction-level pipeline model.
module tb_dlx_ctrl_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] inst_i = '0;
  logic        inst_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [5:0]  ex_func_o;
  logic        ex_imm_sel_o, ex_zero_ext_o, ex_link_o;
  logic [1:0]  ex_branch_o, ex_jmp_o;
  logic        mem_wr_o, mem_rd_o, mem_signed_o;
  logic [1:0]  mem_size_o;
  logic        wb_reg_wr_o, wb_mem_to_reg_o, illegal_op_o;
  logic [4:0]  wb_rd_o;
`ifdef DLX_CTRL_FORWARD_EN
  logic [1:0]  fwd_a_o, fwd_b_o;
`endif

  dlx_ctrl_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .flush_i(flush_i), .stall_o(stall_o), .ex_func_o(ex_func_o),
    .ex_imm_sel_o(ex_imm_sel_o), .ex_zero_ext_o(ex_zero_ext_o), .ex_branch_o(ex_branch_o),
    .ex_jmp_o(ex_jmp_o), .ex_link_o(ex_link_o), .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o),
    .mem_size_o(mem_size_o), .mem_signed_o(mem_signed_o), .wb_reg_wr_o(wb_reg_wr_o),
    .wb_rd_o(wb_rd_o), .wb_mem_to_reg_o(wb_mem_to_reg_o), .illegal_op_o(illegal_op_o)
`ifdef DLX_CTRL_FORWARD_EN
    , .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    bit [5:0] func;
    bit       imm, zext;
    bit [1:0] br, jmp;
    bit       link, mwr, mrd;
    bit [1:0] size;
    bit       sgn, rwr;
    bit [4:0] rd;
    bit       m2r, r1, r2;
    bit [4:0] s1, s2;
    bit       ill;
  } op_t;

  typedef struct packed {
    op_t      ex, mem, wb;
    bit       ill;
    bit [1:0] fa, fb;
  } exp_t;

  exp_t exp_q[$];
  bit   stall_q[$];
  int   total = 0;
  int   bad = 0;

  op_t pex, pmem, pwb;
  bit  ill_m;

  bit [5:0] legal_ops[$] = '{6'h00, 6'h01, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                             6'h0F, 6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C,
                             6'h1D, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h04, 6'h05, 6'h02, 6'h03, 6'h12, 6'h13};

  function automatic op_t bubble();
    op_t o = '0;
    o.func = 6'h22;
    return o;
  endfunction

  function automatic op_t decode(input bit [31:0] w);
    op_t      o = bubble();
    bit [5:0] op = w[31:26];
    o.s1 = w[25:21];
    o.s2 = w[20:16];
    if (op inside {6'h00, 6'h01}) begin
      o.func = w[5:0]; o.rd = w[15:11]; o.rwr = 1; o.r1 = 1; o.r2 = 1;
    end else if (op inside {[6'h08:6'h0E], [6'h18:6'h1D], 6'h14, 6'h16, 6'h17}) begin
      o.func = (op inside {6'h14, 6'h16, 6'h17}) ? op - 6'h10 : op + 6'h18;
      o.imm = 1; o.zext = op inside {6'h0C, 6'h0D, 6'h0E};
      o.rd = w[20:16]; o.rwr = 1; o.r1 = 1;
    end else if (op == 6'h0F) begin
      o.imm = 1; o.rd = w[20:16]; o.rwr = 1;
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      o.func = 6'h20; o.imm = 1; o.mrd = 1; o.m2r = 1; o.rwr = 1; o.rd = w[20:16]; o.r1 = 1;
      o.size = (op == 6'h23) ? 2'd2 : ((op == 6'h21 || op == 6'h25) ? 2'd1 : 2'd0);
      o.sgn  = op inside {6'h20, 6'h21, 6'h23};
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      o.func = 6'h20; o.imm = 1; o.mwr = 1; o.r1 = 1; o.r2 = 1;
      o.size = (op == 6'h2B) ? 2'd2 : ((op == 6'h29) ? 2'd1 : 2'd0);
    end else if (op inside {6'h04, 6'h05}) begin
      o.br = (op == 6'h05) ? 2'b11 : 2'b01; o.r1 = 1;
    end else if (op inside {6'h02, 6'h03, 6'h12, 6'h13}) begin
      o.jmp = (op >= 6'h12) ? 2'b11 : 2'b01;
      o.r1  = (op >= 6'h12);
      if (op == 6'h03 || op == 6'h13) begin o.link = 1; o.rwr = 1; o.rd = 5'd31; end
    end else begin
      o.ill = 1;
    end
    if (o.rd == 0) o.rwr = 0;
    return o;
  endfunction

  // Registers with a write still pending that ID may not yet read from the register file.
  function automatic bit hazard(input op_t d, input op_t ex, input op_t mem);
    bit [31:0] pend = '0;
`ifdef DLX_CTRL_FORWARD_EN
    if (ex.rwr && ex.mrd) pend[ex.rd] = 1'b1;
`else
    if (ex.rwr)  pend[ex.rd]  = 1'b1;
    if (mem.rwr) pend[mem.rd] = 1'b1;
`endif
    pend[0] = 1'b0;
    return (d.r1 && pend[d.s1]) || (d.r2 && pend[d.s2]);
  endfunction

  function automatic bit [1:0] fwd_src(input bit rd_used, input bit [4:0] rs, input op_t ex, input op_t mem);
    if (!rd_used || rs == 0) return 2'b00;
    if (ex.rwr && ex.rd == rs) return 2'b01;
    if (mem.rwr && mem.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit [31:0] w, input bit v, input bit f, input bit r, output bit st);
    op_t  d, iss;
    exp_t e;
    bit [1:0] fa, fb;
    @(negedge clk_i);
    inst_i = w; inst_valid_i = v; flush_i = f; rst_i = r;
    d  = decode(w);
    st = !r && !f && v && hazard(d, pex, pmem);
    stall_q.push_back(st);
    fa = 2'b00; fb = 2'b00;
    if (r) begin
      pex = bubble(); pmem = bubble(); pwb = bubble(); ill_m = 0;
    end else begin
      iss = (f || st || !v) ? bubble() : d;
      if (!(f || st || !v)) begin
        fa = fwd_src(d.r1, d.s1, pex, pmem);
        fb = fwd_src(d.r2, d.s2, pex, pmem);
      end
      if (v && !f && d.ill) ill_m = 1;
      pwb = pmem; pmem = pex; pex = iss;
    end
    e.ex = pex; e.mem = pmem; e.wb = pwb; e.ill = ill_m; e.fa = fa; e.fb = fb;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit [31:0] w, input bit v);
    bit st;
    int n = 0;
    do begin
      step(w, v, 1'b0, 1'b0, st);
      n++;
    end while (st && n < 8);
  endtask

  initial begin : stall_monitor
    forever begin
      @(negedge clk_i);
      #4;
      if (stall_q.size() > 0) chk("stall", 32'(stall_o), 32'(stall_q.pop_front()));
    end
  end

  initial begin : stage_monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_func",       32'(ex_func_o),       32'(e.ex.func));
        chk("ex_imm_sel",    32'(ex_imm_sel_o),    32'(e.ex.imm));
        chk("ex_zero_ext",   32'(ex_zero_ext_o),   32'(e.ex.zext));
        chk("ex_branch",     32'(ex_branch_o),     32'(e.ex.br));
        chk("ex_jmp",        32'(ex_jmp_o),        32'(e.ex.jmp));
        chk("ex_link",       32'(ex_link_o),       32'(e.ex.link));
        chk("mem_wr",        32'(mem_wr_o),        32'(e.mem.mwr));
        chk("mem_rd",        32'(mem_rd_o),        32'(e.mem.mrd));
        chk("mem_size",      32'(mem_size_o),      32'(e.mem.size));
        chk("mem_signed",    32'(mem_signed_o),    32'(e.mem.sgn));
        chk("wb_reg_wr",     32'(wb_reg_wr_o),     32'(e.wb.rwr));
        chk("wb_rd",         32'(wb_rd_o),         32'(e.wb.rd));
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg_o), 32'(e.wb.m2r));
        chk("illegal_op",    32'(illegal_op_o),    32'(e.ill));
`ifdef DLX_CTRL_FORWARD_EN
        chk("fwd_a", 32'(fwd_a_o), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b_o), 32'(e.fb));
`endif
      end
    end
  end

  initial begin : stimulus
    bit          st;
    bit [31:0]   w;
    bit          v, f, r;
    pex = bubble(); pmem = bubble(); pwb = bubble(); ill_m = 0;

    step(32'h0, 0, 0, 1, st);
    step(32'h0, 0, 0, 1, st);
    issue(32'h00221820, 1);                  // ADD r3,r1,r2
    repeat (3) issue(32'h0, 0);
    issue(32'h8C250000, 1);                  // LW r5,0(r1)
    issue(32'h00A53020, 1);                  // ADD r6,r5,r5
    repeat (3) issue(32'h0, 0);
    issue(32'h34200007, 1);                  // ORI r0,r1,#7
    issue(32'h0C000010, 1);                  // JAL
    repeat (3) issue(32'h0, 0);
    issue(32'h8C250000, 1);                  // LW r5 then flushed dependent ADD
    step(32'h00A53020, 1, 1, 0, st);
    issue(32'h00221820, 1);
    repeat (3) issue(32'h0, 0);
    issue(32'h00221820, 1);                  // ADD r3 then SUB r4,r3,r3
    issue(32'h00632022, 1);
    issue(32'h00221820, 1);                  // same with one NOP between
    issue(32'h0, 0);
    issue(32'h00632022, 1);
    issue(32'hFC000000, 1);                  // opcode 0x3F
    repeat (3) issue(32'h0, 0);
    issue(32'h8C250000, 1);
    step(32'h00A53020, 1, 0, 1, st);         // reset mid-stream
    repeat (3) issue(32'h0, 0);

    st = 0;
    for (int i = 0; i < 800; i++) begin
      if (!st) begin
        w = $urandom();
        if ($urandom_range(0, 99) == 0) w[31:26] = 6'h3F;
        else w[31:26] = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        v = ($urandom_range(0, 7) != 0);
      end
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 59) == 0);
      step(w, v, f, r, st);
    end

    repeat (4) step(32'h0, 0, 0, 0, st);
    repeat (2) @(posedge clk_i);
    #3;
    chk("drain", 32'(exp_q.size() + stall_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlx_ctrl_pipe.md
Name: dlx_ctrl_pipe

Overview:
- Pipelined control unit for the 32-bit DLX datapath.
- Decodes the instruction in ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Generates the fetch stall for read-after-write hazards and inserts bubbles on stall or on a flush from branch resolution.
- Sits between the fetch/IR register and the ALU (add_32_lookahead-based), memory and register-file write-back.

Parameters:
- FUNC_W, 6: ALU function code width.
- REG_AW, 5: register address width.
- LINK_REG, 31: destination register for JAL/JALR.
- DEFAULT_FUNC, 6'h22: ALU function for non-ALU opcodes and bubbles (subtract).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst  in  32  instruction currently in ID.
- inst_valid  in  1  ID holds a real instruction.
- flush  in  1  branch/jump taken in EX; kill the ID instruction.
- stall  out  1  hold PC and IR this cycle (combinational).
- ex_func  out  FUNC_W  ALU function, EX stage.
- ex_imm_sel  out  1  ALU B operand is the immediate.
- ex_zero_ext  out  1  zero-extend the immediate (ANDI/ORI/XORI).
- ex_branch  out  2  bit0 = BEQZ/BNEZ, bit1 = 1 for BNEZ.
- ex_jmp  out  2  bit0 = jump, bit1 = register target (JR/JALR).
- ex_link  out  1  write PC+4 (JAL/JALR).
- mem_wr  out  1  store, MEM stage.
- mem_rd  out  1  load, MEM stage.
- mem_size  out  2  00 = byte, 01 = half, 10 = word.
- mem_signed  out  1  sign-extend load data (LB/LH/LW).
- wb_reg_wr  out  1  register write enable, WB stage.
- wb_rd  out  REG_AW  write-back register address.
- wb_mem_to_reg  out  1  write-back source is load data.
- illegal_op  out  1  sticky unknown-opcode flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, and all state is cleared on the rising edge of clk while rst=1.
- Reset: all stage registers hold a bubble. A bubble is all enables 0, func=DEFAULT_FUNC, rd=0, size=00. illegal_op=0. Reset asserted mid-stream discards every in-flight instruction on that edge.
- Decode (ID, combinational) by opcode inst[31:26]:
  - 00/01: R-type; func=inst[5:0]; rd=inst[15:11]; reads rs1 and rs2.
  - 08–0E, 14, 16, 17, 18–1D: immediate ALU; func=opcode+0x18 for 08–0E and 18–1D, opcode−0x10 for 14/16/17; rd=inst[20:16]; reads rs1.
  - 0F: LHI; rd=inst[20:16]; reads nothing.
  - 20/21/23/24/25: load; func=20 (add); rd=inst[20:16]; reads rs1.
  - 28/29/2B: store; func=20; reads rs1 and rs2; no write.
  - 04/05: branch; reads rs1.
  - 02/03: J/JAL; reads nothing.
  - 12/13: JR/JALR; reads rs1.
  - JAL/JALR: rd=LINK_REG.
- Write suppression: reg_wr is forced to 0 whenever rd=0.
- Illegal opcodes: any other opcode decodes to a bubble and, if inst_valid=1 and not flushed, sets illegal_op until reset.
- Hazards (no forwarding): stall=1 when inst_valid=1 and a register read by ID equals a non-zero rd of EX or MEM with reg_wr=1. The register file is write-first, so WB never stalls.
- Priority on each edge:
  - flush=1: ID/EX loads a bubble; stall is ignored.
  - else stall=1: ID/EX loads a bubble.
  - else ID/EX loads the decoded bundle (a bubble if inst_valid=0).
  - EX/MEM and MEM/WB always advance.
- Latency: an instruction's EX signals appear 1 cycle after ID capture, MEM signals after 2 cycles, WB signals after 3 cycles.
- The stall output is driven to 0 while rst=1.

Optional Feature:
- Macro: DLX_CTRL_FORWARD_EN.
- When defined:
  - Adds outputs fwd_a and fwd_b (2 bits each, registered into EX): 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result. EX/MEM takes priority when both match; rd=0 never forwards.
  - stall only for load-use: the EX stage is a load whose rd is read by ID (1 bubble).
- When undefined: fwd_a and fwd_b are absent, and the full RAW stall rule above applies.

Test Plan:
- Reset, then ADD r3,r1,r2 (0x00221820) → 3 cycles later wb_reg_wr=1, wb_rd=3; ex_func=0x20 one cycle after capture.
- LW r5,0(r1) then ADD r6,r5,r5 → stall=1 for 1 cycle with forwarding, 2 cycles without; one bubble in EX per stall cycle; mem_size=10, mem_signed=1.
- ORI r0,r1,#7 → ex_zero_ext=1, ex_func=0x25, wb_reg_wr=0 (rd=0). JAL → wb_rd=31, ex_link=1.
- flush=1 and stall condition asserted together → next EX is a bubble, and the IR-held instruction is not duplicated.
- Opcode 0x3F with inst_valid=1 → illegal_op=1 and stays 1; rst=1 for one edge → illegal_op=0 and all stage outputs are bubbles.
- (FORWARD_EN) ADD r3 then SUB r4,r3,r3 → no stall, fwd_a=fwd_b=01; with one NOP between them → fwd_a=fwd_b=10.
